cavlc_bit_packer: RTL and testbench
===================================

CAVLC_BIT_PACKER -- requirements
Module: cavlc_bit_packer

Interface
REQ-001 SHALL have ports: Clk  in  1  clock, rising edge; nReset  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have port Enable  in  1  start/continue block packing from external control.
REQ-003 SHALL have ports CodeValid  in  1, CodeReady  out  1  codeword handshake; transfer when both high on a rising Clk edge.
REQ-004 SHALL have ports CodeValue  in  16  right-justified codeword; CodeLen  in  5  bit count 0..16; CodeLast  in  1  last codeword of block.
REQ-005 SHALL have ports OutValid  out  1, OutReady  in  1  output word handshake; OutWord  out  32  packed bits, bit 31 first in stream; OutLast  out  1  final word of block.
REQ-006 SHALL have ports BlockDone  out  1  one-cycle block-complete pulse; BitCount  out  16  code bits accepted in current block.

Function
REQ-007 SHALL pack codewords MSB-first: bit CodeLen-1 of CodeValue first; bits at or above CodeLen ignored.
REQ-008 SHALL treat CodeLen >16 as 16; CodeLen=0 completes handshake and adds no bits.
REQ-009 SHALL hold a 48-bit left-aligned accumulator with fill level Fill in 0..47.
REQ-010 SHALL implement states IDLE, PACK, FLUSH, DONE.
REQ-011 IDLE->PACK when Enable=1; IDLE->IDLE otherwise; BitCount cleared on this transition.
REQ-012 In PACK, CodeReady=1 iff Fill<32; OutValid=1 iff Fill>=32; the two never both high.
REQ-013 On code handshake, Fill+=CodeLen and BitCount+=CodeLen, saturating at 0xFFFF; if CodeLast=1, PACK->FLUSH.
REQ-014 On output handshake, accumulator shifts left 32 and Fill-=32.
REQ-015 A word reaching Fill>=32 on a code handshake in cycle N SHALL present OutValid in cycle N+1.
REQ-016 In FLUSH, CodeReady=0. If Fill>0, OutValid=1 with remaining bits left-aligned, LSBs zero-padded. After the handshake Fill=max(Fill-32,0).
REQ-017 FLUSH->DONE when Fill=0 and no trailing bit is pending.
REQ-018 OutLast=1 only with the final OutValid word of a block.
REQ-019 DONE asserts BlockDone for exactly one cycle. DONE->PACK if Enable=1, else DONE->IDLE.
REQ-020 While OutValid=1 and OutReady=0, OutWord and OutLast SHALL hold stable.
REQ-021 Enable deasserting mid-block SHALL NOT abort the block; it affects only the DONE exit.

Reset
REQ-022 On nReset low, the block SHALL enter IDLE and clear the accumulator and Fill; CodeReady, OutValid, OutWord, OutLast, BlockDone and BitCount SHALL be 0.
REQ-023 Reset mid-block SHALL discard all partial data with no output; the first block after reset starts clean.

Configuration
REQ-024 With macro CAVLC_RBSP_TRAIL_EN defined, on entering FLUSH a single '1' stop bit is appended after the last code bit, followed by zero padding (rbsp trailing bits).
REQ-025 Under CAVLC_RBSP_TRAIL_EN, Fill=0 at FLUSH entry SHALL still emit word 0x80000000 with OutLast=1.
REQ-026 Under CAVLC_RBSP_TRAIL_EN, the stop bit is never counted in BitCount.
REQ-027 Without CAVLC_RBSP_TRAIL_EN, flush pads with zeros only; Fill=0 at FLUSH entry emits no word.

Verification
REQ-028 Codes (0x1,len1),(0x1,len3),(0x5,len3,Last), OutReady=1 -> one word 0x9A000000 (0x9B000000 with macro), OutLast=1, BitCount=7, BlockDone pulse after it.
REQ-029 Codes (0xFFFF,16),(0xFFFF,16,Last) -> word 0xFFFFFFFF OutLast=1 (no macro); with macro 0xFFFFFFFF OutLast=0, then 0x80000000 OutLast=1.
REQ-030 Fill=40, OutReady held 0 for 5 cycles -> CodeReady=0 and OutWord stable throughout; word accepted on cycle 6, then CodeReady=1 with Fill=8.
REQ-031 Code (0xABCDE truncated input 0xBCDE, CodeLen=20, Last) -> treated as 16 bits, word 0xBCDE0000, BitCount=16.
REQ-032 nReset pulsed in PACK with Fill=20 -> all outputs 0 next cycle; Enable then code (0x3,2,Last) -> word 0xC0000000, BitCount=2.
REQ-033 Enable=1 held through DONE -> BlockDone pulses 1 cycle and CodeReady=1 the following cycle with BitCount=0.

Source files
------------

// File: rtl/cavlc_bit_packer.sv
// CAVLC codeword bit packer: MSB-first codes into 32-bit output words.
// Optional rbsp trailing stop bit on flush: define CAVLC_RBSP_TRAIL_EN.
module cavlc_bit_packer (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        Enable,
    input  logic        CodeValid,
    output logic        CodeReady,
    input  logic [15:0] CodeValue,
    input  logic [4:0]  CodeLen,
    input  logic        CodeLast,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutWord,
    output logic        OutLast,
    output logic        BlockDone,
    output logic [15:0] BitCount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PACK,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [47:0] acc_q, acc_d;
    logic [5:0]  fill_q, fill_d;
    logic [15:0] bcnt_q, bcnt_d;

    logic [4:0]  len_c;
    logic [16:0] mask;
    logic [15:0] code_m;
    logic [5:0]  sh;
    logic [47:0] ins;
    logic [16:0] bc_sum;
    logic [15:0] bc_sat;
    logic [47:0] eff_acc;
    logic [5:0]  eff_fill;
    logic        code_hs;
    logic        out_hs;

`ifdef CAVLC_RBSP_TRAIL_EN
    logic        trail_q, trail_d;
`endif

    // Clamp/mask the codeword and place it just below the current fill.
    // The stop bit is kept pending and merged only into the flush view.
    always_comb begin
        len_c  = (CodeLen > 5'd16) ? 5'd16 : CodeLen;
        mask   = (17'd1 << len_c) - 17'd1;
        code_m = CodeValue & mask[15:0];
        sh     = 6'd48 - fill_q - {1'b0, len_c};
        ins    = {32'd0, code_m} << sh;
        bc_sum = {1'b0, bcnt_q} + {12'd0, len_c};
        bc_sat = bc_sum[16] ? 16'hFFFF : bc_sum[15:0];
`ifdef CAVLC_RBSP_TRAIL_EN
        eff_acc  = trail_q ? (acc_q | (48'h8000_0000_0000 >> fill_q))
                           : acc_q;
        eff_fill = fill_q + {5'd0, trail_q};
`else
        eff_acc  = acc_q;
        eff_fill = fill_q;
`endif
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        fill_d    = fill_q;
        bcnt_d    = bcnt_q;
        CodeReady = 1'b0;
        OutValid  = 1'b0;
        OutWord   = 32'd0;
        OutLast   = 1'b0;
        BlockDone = 1'b0;
        code_hs   = 1'b0;
        out_hs    = 1'b0;
`ifdef CAVLC_RBSP_TRAIL_EN
        trail_d   = trail_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (Enable) begin
                    state_d = S_PACK;
                    bcnt_d  = 16'd0;
                end
            end
            S_PACK: begin
                CodeReady = (fill_q < 6'd32);
                OutValid  = ~CodeReady;
                OutWord   = OutValid ? acc_q[47:16] : 32'd0;
                code_hs   = CodeValid & CodeReady;
                out_hs    = OutValid & OutReady;
                if (code_hs) begin
                    acc_d  = acc_q | ins;
                    fill_d = fill_q + {1'b0, len_c};
                    bcnt_d = bc_sat;
                    if (CodeLast) begin
                        state_d = S_FLUSH;
`ifdef CAVLC_RBSP_TRAIL_EN
                        trail_d = 1'b1;
`endif
                    end
                end else if (out_hs) begin
                    acc_d  = acc_q << 32;
                    fill_d = fill_q - 6'd32;
                end
            end
            S_FLUSH: begin
                OutValid = (eff_fill != 6'd0);
                OutWord  = eff_acc[47:16];
                OutLast  = OutValid && (eff_fill <= 6'd32);
                out_hs   = OutValid & OutReady;
                if (!OutValid) begin
                    state_d = S_DONE;
                    acc_d   = 48'd0;
                    fill_d  = 6'd0;
                end else if (out_hs) begin
`ifdef CAVLC_RBSP_TRAIL_EN
                    trail_d = 1'b0;
`endif
                    if (eff_fill > 6'd32) begin
                        acc_d  = eff_acc << 32;
                        fill_d = eff_fill - 6'd32;
                    end else begin
                        acc_d   = 48'd0;
                        fill_d  = 6'd0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                BlockDone = 1'b1;
                if (Enable) begin
                    state_d = S_PACK;
                    bcnt_d  = 16'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            acc_q   <= 48'd0;
            fill_q  <= 6'd0;
            bcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            bcnt_q  <= bcnt_d;
        end
    end

`ifdef CAVLC_RBSP_TRAIL_EN
    // Pending stop bit, cleared once it has left in a word.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) trail_q <= 1'b0;
        else         trail_q <= trail_d;
    end
`endif

    assign BitCount = bcnt_q;

endmodule

// File: tb/tb_cavlc_bit_packer.sv
// Bench for cavlc_bit_packer: bit-queue reference model,
// directed scenarios and randomized blocks.
module tb_cavlc_bit_packer;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic        Enable = 1'b0;
    logic        CodeValid = 1'b0;
    logic        CodeReady;
    logic [15:0] CodeValue = 16'd0;
    logic [4:0]  CodeLen = 5'd0;
    logic        CodeLast = 1'b0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [31:0] OutWord;
    logic        OutLast;
    logic        BlockDone;
    logic [15:0] BitCount;

    int n_tests = 0;
    int n_fail  = 0;

    cavlc_bit_packer dut (
        .Clk       (Clk),
        .nReset    (nReset),
        .Enable    (Enable),
        .CodeValid (CodeValid),
        .CodeReady (CodeReady),
        .CodeValue (CodeValue),
        .CodeLen   (CodeLen),
        .CodeLast  (CodeLast),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutWord   (OutWord),
        .OutLast   (OutLast),
        .BlockDone (BlockDone),
        .BitCount  (BitCount)
    );

    always #5 Clk = ~Clk;

`ifdef CAVLC_RBSP_TRAIL_EN
    localparam bit TRAIL = 1'b1;
`else
    localparam bit TRAIL = 1'b0;
`endif

    // reference model state
    bit          bq[$];
    logic [32:0] exq[$];
    int          exp_bc[$];
    logic [32:0] wlog[$];
    int          blk_bits = 0;

    // monitor state
    bit          code_acc = 0;
    bit          done_seen = 0;
    logic [15:0] done_bc = 16'd0;
    bit          prev_done = 0;
    bit          stall_q = 0;
    logic [32:0] stall_w = 33'd0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic emit(input bit last);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < 32; i++)
            if (bq.size() > 0) w[31-i] = bq.pop_front();
        exq.push_back({last, w});
    endtask

    // Stream-level model: bits in order, cut into 32-bit words.
    task automatic model_code(input logic [15:0] v, input logic [4:0] len,
                              input bit last);
        int l;
        l = (len > 16) ? 16 : int'(len);
        for (int i = l - 1; i >= 0; i--) bq.push_back(v[i]);
        blk_bits += l;
        if (!last) begin
            while (bq.size() >= 32) emit(1'b0);
        end else begin
            if (TRAIL) bq.push_back(1'b1);
            while (bq.size() > 0) emit(bq.size() <= 32);
            exp_bc.push_back(blk_bits > 65535 ? 65535 : blk_bits);
            blk_bits = 0;
        end
    endtask

    task automatic model_clear();
        bq.delete();
        exq.delete();
        exp_bc.delete();
        blk_bits  = 0;
        stall_q   = 0;
        prev_done = 0;
    endtask

    task automatic monitor();
        logic [32:0] e;
        if (!nReset) return;
        chk("rdy_vld_excl", {31'd0, CodeReady & OutValid}, 32'd0);
        if (stall_q)
            chk("stall_hold", {OutValid, OutWord}, {1'b1, stall_w[31:0]});
        if (stall_q)
            chk("stall_last", {31'd0, OutLast}, {31'd0, stall_w[32]});
        stall_q = OutValid && !OutReady;
        stall_w = {OutLast, OutWord};
        if (OutValid && OutReady) begin
            wlog.push_back({OutLast, OutWord});
            if (exq.size() == 0) begin
                chk("spurious_word", OutWord, 32'hDEAD_BEEF);
            end else begin
                e = exq.pop_front();
                chk("word", OutWord, e[31:0]);
                chk("outlast", {31'd0, OutLast}, {31'd0, e[32]});
            end
        end
        if (BlockDone) begin
            chk("done_width", {31'd0, prev_done}, 32'd0);
            done_seen = 1;
            done_bc = BitCount;
            if (exp_bc.size() == 0)
                chk("spurious_done", 32'd1, 32'd0);
            else
                chk("bitcount", {16'd0, BitCount},
                    exp_bc.pop_front());
            chk("done_words_left", exq.size(), 0);
        end
        prev_done = BlockDone;
        if (CodeValid && CodeReady) begin
            code_acc = 1;
            model_code(CodeValue, CodeLen, CodeLast);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
        monitor();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_ready(input int mode);
        case (mode)
            0: OutReady = 1'b0;
            1: OutReady = 1'b1;
            default: OutReady = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic send_code(input logic [15:0] v, input logic [4:0] len,
                             input bit last, input int mode);
        int n;
        CodeValid = 1'b1;
        CodeValue = v;
        CodeLen   = len;
        CodeLast  = last;
        code_acc  = 0;
        n = 0;
        while (!code_acc && n < 300) begin
            set_ready(mode);
            cyc();
            n++;
        end
        if (!code_acc) chk("code_timeout", 32'd0, 32'd1);
        CodeValid = 1'b0;
        CodeLast  = 1'b0;
    endtask

    task automatic wait_done(input int mode);
        int n;
        done_seen = 0;
        n = 0;
        while (!done_seen && n < 500) begin
            set_ready(mode);
            cyc();
            n++;
        end
        if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
        OutReady = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_crdy"}, {31'd0, CodeReady}, 32'd0);
        chk({tag, "_ovld"}, {31'd0, OutValid}, 32'd0);
        chk({tag, "_oword"}, OutWord, 32'd0);
        chk({tag, "_olast"}, {31'd0, OutLast}, 32'd0);
        chk({tag, "_bdone"}, {31'd0, BlockDone}, 32'd0);
        chk({tag, "_bcnt"}, {16'd0, BitCount}, 32'd0);
    endtask

    initial begin
        logic [15:0] v;
        logic [4:0]  l;
        int          nc;

        repeat (3) @(posedge Clk);
        #1;
        check_zero("reset");
        nReset = 1'b1;
        repeat (2) cyc();
        chk("idle_crdy", {31'd0, CodeReady}, 32'd0);

        // three short codes into one word
        Enable = 1'b1;
        wlog.delete();
        send_code(16'h1, 5'd1, 1'b0, 1);
        send_code(16'h1, 5'd3, 1'b0, 1);
        send_code(16'h5, 5'd3, 1'b1, 1);
        wait_done(1);
        chk("r28_nwords", wlog.size(), 1);
        chk("r28_word", wlog[0][31:0], TRAIL ? 32'h9B00_0000 : 32'h9A00_0000);
        chk("r28_last", {31'd0, wlog[0][32]}, 32'd1);
        chk("r28_bcnt", {16'd0, done_bc}, 32'd7);
        chk("r33_crdy", {31'd0, CodeReady}, 32'd1);
        chk("r33_bcnt", {16'd0, BitCount}, 32'd0);
        chk("r33_bdone", {31'd0, BlockDone}, 32'd0);

        // exactly 32 bits in the block
        wlog.delete();
        send_code(16'hFFFF, 5'd16, 1'b0, 1);
        send_code(16'hFFFF, 5'd16, 1'b1, 1);
        wait_done(1);
        chk("r29_nwords", wlog.size(), TRAIL ? 2 : 1);
        chk("r29_w0", wlog[0][31:0], 32'hFFFF_FFFF);
        chk("r29_l0", {31'd0, wlog[0][32]}, TRAIL ? 32'd0 : 32'd1);
        if (TRAIL) begin
            chk("r29_w1", wlog[1][31:0], 32'h8000_0000);
            chk("r29_l1", {31'd0, wlog[1][32]}, 32'd1);
        end

        // output backpressure with Fill=40
        wlog.delete();
        send_code(16'hFFFF, 5'd16, 1'b0, 0);
        send_code(16'h00FF, 5'd8, 1'b0, 0);
        send_code(16'hFFFF, 5'd16, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            OutReady = 1'b0;
            cyc();
            chk("r30_crdy", {31'd0, CodeReady}, 32'd0);
            chk("r30_word", OutWord, 32'hFFFF_FFFF);
        end
        OutReady = 1'b1;
        cyc();
        OutReady = 1'b0;
        chk("r30_accepted", wlog.size(), 1);
        chk("r30_crdy_after", {31'd0, CodeReady}, 32'd1);
        chk("r30_ovld_after", {31'd0, OutValid}, 32'd0);
        send_code(16'h00AB, 5'd8, 1'b1, 1);
        wait_done(1);
        chk("r30_tail", wlog[1][31:0],
            TRAIL ? 32'hFFAB_8000 : 32'hFFAB_0000);

        // oversize CodeLen clamps to 16
        wlog.delete();
        send_code(16'hBCDE, 5'd20, 1'b1, 1);
        wait_done(1);
        chk("r31_word", wlog[0][31:0],
            TRAIL ? 32'hBCDE_8000 : 32'hBCDE_0000);
        chk("r31_bcnt", {16'd0, done_bc}, 32'd16);

        // CodeLen=0 last code on an empty block
        wlog.delete();
        send_code(16'hFFFF, 5'd0, 1'b1, 1);
        wait_done(1);
        chk("len0_nwords", wlog.size(), TRAIL ? 1 : 0);
        chk("len0_bcnt", {16'd0, done_bc}, 32'd0);

        // reset in the middle of a block
        send_code(16'hFFFF, 5'd16, 1'b0, 1);
        send_code(16'h000F, 5'd4, 1'b0, 1);
        nReset = 1'b0;
        #1;
        check_zero("r32_async");
        model_clear();
        @(posedge Clk);
        #1;
        check_zero("r32_next");
        nReset = 1'b1;
        wlog.delete();
        send_code(16'h0003, 5'd2, 1'b1, 1);
        wait_done(1);
        chk("r32_nwords", wlog.size(), 1);
        chk("r32_word", wlog[0][31:0],
            TRAIL ? 32'hE000_0000 : 32'hC000_0000);
        chk("r32_bcnt", {16'd0, done_bc}, 32'd2);

        // Enable drop mid-block: block completes, then idle
        send_code(16'h0005, 5'd3, 1'b0, 1);
        Enable = 1'b0;
        send_code(16'h0001, 5'd2, 1'b1, 1);
        wait_done(1);
        cyc();
        chk("r21_idle_crdy", {31'd0, CodeReady}, 32'd0);
        chk("r21_idle_bcnt", {16'd0, BitCount}, 32'd5);
        Enable = 1'b1;

        // randomized blocks
        for (int b = 0; b < 40; b++) begin
            nc = $urandom_range(1, 12);
            for (int c = 0; c < nc; c++) begin
                v = 16'($urandom);
                l = 5'($urandom_range(0, 20));
                send_code(v, l, c == nc - 1, 2);
                if ($urandom_range(0, 3) == 0) begin
                    set_ready(2);
                    cyc();
                end
            end
            wait_done(2);
        end

        // BitCount saturation
        for (int c = 0; c < 4100; c++) begin
            v = 16'($urandom);
            l = 5'($urandom_range(16, 20));
            send_code(v, l, c == 4099, 1);
        end
        wait_done(1);
        chk("sat_bcnt", {16'd0, done_bc}, 32'h0000_FFFF);

        chk("end_words_left", exq.size(), 0);
        chk("end_blocks_left", exp_bc.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
